// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and constants for the LED matrix scan path.
package pong_pkg;

  localparam int unsigned MATRIX_COLS    = 16;
  localparam int unsigned MATRIX_ROWS    = 16;
  // Clocks spent per serial column bit (addr, data, hi, lo).
  localparam int unsigned COL_BIT_CYCLES = 4;
  // Row strobe (setup, hi, lo) plus the latch cycle.
  localparam int unsigned ROW_OVERHEAD   = 4;

  typedef enum logic [3:0] {
    StIdle,
    StColAddr,
    StColData,
    StColHi,
    StColLo,
    StRowSetup,
    StRowHi,
    StRowLo,
    StLatch,
    StDisplay
  } scan_state_t;

  // Phase of one serial bit as seen by a shifter instance.
  typedef enum logic [2:0] {
    PhIdle,
    PhAddr,
    PhData,
    PhHi,
    PhLo
  } bit_phase_t;

  // Columns leave the controller highest first.
  function automatic logic [3:0] col_to_x(input logic [4:0] col);
    return 4'(MATRIX_COLS - 1) - col[3:0];
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Framebuffer read port and LED matrix driver pins.
interface matrix_scan_ctrl_if;

  logic [3:0] pix_x;
  logic [3:0] pix_y;
  logic       pix_in;
  logic       CSDI;
  logic       CCLK;
  logic       RSDI;
  logic       RCLK;
  logic       LE;
  logic       OEB;

  // Scan controller side.
  modport master (
    output pix_x, pix_y, CSDI, CCLK, RSDI, RCLK, LE, OEB,
    input  pix_in
  );

  // Framebuffer and matrix side.
  modport slave (
    input  pix_x, pix_y, CSDI, CCLK, RSDI, RCLK, LE, OEB,
    output pix_in
  );

endinterface

// File: rtl/matrix_scan_ctrl_serial_bit_shifter.sv
// One serial bit lane: samples data in the data phase, pulses the shift clock in the hi phase.
module serial_bit_shifter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  bit_phase_t phase,
  input  logic       data,
  output logic       sdata,
  output logic       sclk
);

  logic sdata_q;

  // Capture the bit once per bit period and hold it across the clock pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_q <= 1'b0;
    end else if (phase == PhData) begin
      sdata_q <= data;
    end
  end

  // Shift clock is a pure decode of the phase so reset drops it at once.
  always_comb begin
    sclk  = (phase == PhHi);
    sdata = sdata_q;
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-at-a-time scan controller for the 16x16 LED matrix.
module matrix_scan_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREENTIMERWIDTH = 10,
  parameter int unsigned COLS             = MATRIX_COLS,
  parameter int unsigned ROWS             = MATRIX_ROWS
) (
  input  logic                      clk32mhz,
  input  logic                      reset_n,
  input  logic                      enable,
  matrix_scan_ctrl_if.master        mx,
  output logic                      frame_start,
  output logic [3:0]                row
);

  scan_state_t                 state_q, state_d;
  logic [4:0]                  col_q, col_d;
  logic [3:0]                  row_q, row_d;
  logic [SCREENTIMERWIDTH-1:0] timer_q, timer_d;
  logic                        timer_done;
  logic                        last_col;
  logic                        row_inject;
  bit_phase_t                  col_phase;
  bit_phase_t                  row_phase;

  assign timer_done = (timer_q == '1);
  assign last_col   = (col_q == 5'(COLS - 1));
  // The one-hot row token is re-seeded only while row 0 is shifted.
  assign row_inject = (row_q == 4'd0);

  assign mx.pix_y = row_q;
  assign row      = row_q;

  // State register.
  always_ff @(posedge clk32mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Column, row and display timer registers.
  always_ff @(posedge clk32mhz or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      timer_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: enable is only looked at in idle and at the end of a row.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (enable) state_d = StColAddr;
      StColAddr:  state_d = StColData;
      StColData:  state_d = StColHi;
      StColHi:    state_d = StColLo;
      StColLo:    state_d = last_col ? StRowSetup : StColAddr;
      StRowSetup: state_d = StRowHi;
      StRowHi:    state_d = StRowLo;
      StRowLo:    state_d = StLatch;
      StLatch:    state_d = StDisplay;
      StDisplay:  if (timer_done) state_d = enable ? StColAddr : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Counter updates; the timer sits at zero outside the display window.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    timer_d = '0;
    unique case (state_q)
      StIdle, StRowSetup: col_d = '0;
      StColLo:            col_d = col_q + 5'd1;
      StDisplay: begin
        timer_d = timer_q + 1'b1;
        if (timer_done) begin
          row_d = (row_q == 4'(ROWS - 1)) ? 4'd0 : row_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Moore outputs: display is blanked everywhere except the display window.
  always_comb begin
    mx.OEB      = 1'b1;
    mx.LE       = 1'b0;
    mx.pix_x    = '0;
    frame_start = 1'b0;
    col_phase   = PhIdle;
    row_phase   = PhIdle;
    unique case (state_q)
      StColAddr: begin
        col_phase   = PhAddr;
        mx.pix_x    = col_to_x(col_q);
        frame_start = (row_q == 4'd0) && (col_q == 5'd0);
      end
      StColData:  col_phase = PhData;
      StColHi:    col_phase = PhHi;
      StColLo:    col_phase = PhLo;
      StRowSetup: row_phase = PhData;
      StRowHi:    row_phase = PhHi;
      StRowLo:    row_phase = PhLo;
      StLatch:    mx.LE     = 1'b1;
      StDisplay:  mx.OEB    = 1'b0;
      default: ;
    endcase
  end

  serial_bit_shifter u_col_shifter (
    .clk   (clk32mhz),
    .rst_n (reset_n),
    .phase (col_phase),
    .data  (mx.pix_in),
    .sdata (mx.CSDI),
    .sclk  (mx.CCLK)
  );

  serial_bit_shifter u_row_shifter (
    .clk   (clk32mhz),
    .rst_n (reset_n),
    .phase (row_phase),
    .data  (row_inject),
    .sdata (mx.RSDI),
    .sclk  (mx.RCLK)
  );

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed and randomized bench for matrix_scan_ctrl with a framebuffer model.
module tb_matrix_scan_ctrl;
  import pong_pkg::*;

  localparam int unsigned TW         = 4;
  localparam int          ROW_PERIOD = int'(MATRIX_COLS * COL_BIT_CYCLES + ROW_OVERHEAD) + 2 ** TW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_start;
  logic [3:0] row;

  matrix_scan_ctrl_if mx ();

  matrix_scan_ctrl #(
    .SCREENTIMERWIDTH (TW),
    .COLS             (16),
    .ROWS             (16)
  ) dut (
    .clk32mhz    (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mx          (mx),
    .frame_start (frame_start),
    .row         (row)
  );

  always #5 clk = ~clk;

  // Framebuffer with a registered read; lat2 adds one extra cycle of read latency.
  logic fb [16][16];
  logic lat2 = 1'b0;
  logic stage1 = 1'b0;
  logic pix_q = 1'b0;
  always @(posedge clk) begin
    stage1 <= fb[mx.pix_y][mx.pix_x];
    pix_q  <= lat2 ? stage1 : fb[mx.pix_y][mx.pix_x];
  end
  assign mx.pix_in = pix_q;

  // Pin monitor: records shifted words, strobes, display windows and invariant breaks.
  logic        clr = 1'b0;
  int          cyc = 0;
  logic        prev_cclk = 1'b0, prev_rclk = 1'b0, prev_oeb = 1'b1;
  logic [15:0] word = '0;
  int          n_cclk_row = 0, n_cclk_tot = 0, n_rclk = 0, n_le_row = 0, n_le_tot = 0;
  int          le_viol = 0, inv_viol = 0, oeb_run = 0, n_oeb = 0, n_fs = 0;
  logic [15:0] words [64];
  logic        rsdis [64];
  logic [3:0]  rows_at [64];
  int          ccnt [64];
  int          rclk_cyc [64];
  int          oeb_runs [64];
  int          fs_cyc [64];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_cclk <= mx.CCLK;
    prev_rclk <= mx.RCLK;
    prev_oeb  <= mx.OEB;
    if (clr) begin
      n_cclk_row <= 0; n_cclk_tot <= 0; n_rclk <= 0; n_le_row <= 0; n_le_tot <= 0;
      le_viol <= 0; inv_viol <= 0; oeb_run <= 0; n_oeb <= 0; n_fs <= 0; word <= '0;
    end else if (!reset_n) begin
      n_cclk_row <= 0; n_le_row <= 0; oeb_run <= 0; word <= '0;
    end else begin
      if (mx.CCLK && !prev_cclk) begin
        word       <= {word[14:0], mx.CSDI};
        n_cclk_row <= n_cclk_row + 1;
        n_cclk_tot <= n_cclk_tot + 1;
      end
      if (mx.RCLK && !prev_rclk) begin
        words[n_rclk[5:0]]    <= word;
        rsdis[n_rclk[5:0]]    <= mx.RSDI;
        rows_at[n_rclk[5:0]]  <= row;
        ccnt[n_rclk[5:0]]     <= n_cclk_row;
        rclk_cyc[n_rclk[5:0]] <= cyc;
        n_rclk                <= n_rclk + 1;
        n_cclk_row            <= 0;
        n_le_row              <= 0;
        word                  <= '0;
      end
      if (mx.LE) begin
        n_le_tot <= n_le_tot + 1;
        n_le_row <= n_le_row + 1;
        if (n_le_row >= 1) le_viol <= le_viol + 1;
      end
      if (!mx.OEB) begin
        oeb_run <= oeb_run + 1;
      end else if (!prev_oeb) begin
        oeb_runs[n_oeb[5:0]] <= oeb_run;
        n_oeb                <= n_oeb + 1;
        oeb_run              <= 0;
      end
      if ((mx.CCLK || mx.RCLK || mx.LE) && !mx.OEB) inv_viol <= inv_viol + 1;
      if (frame_start) begin
        fs_cyc[n_fs[5:0]] <= cyc;
        n_fs              <= n_fs + 1;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic fb_fill(input logic random_fill);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        fb[y][x] = random_fill ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  // Expected shifted word: after 16 MSB-first shifts, bit x holds column x.
  function automatic logic [15:0] ref_word(input int r);
    logic [15:0] w;
    for (int x = 0; x < 16; x++) w[x] = fb[r][x];
    return w;
  endfunction

  initial begin
    int noeb;
    int ctot;

    // Reset state.
    fb_fill(1'b0);
    fb[0][3] = 1'b1;
    tick();
    tick();
    check("reset_pins", 32'({mx.CSDI, mx.CCLK, mx.RSDI, mx.RCLK, mx.LE, mx.OEB, frame_start}),
          32'(7'b0000010));
    check("reset_pix", 32'({mx.pix_x, mx.pix_y}), 32'(0));
    check("reset_row", 32'(row), 32'(0));

    // Single lit pixel (3,0): one row shifted out.
    clear_monitor();
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 300 && n_oeb < 1; i++) tick();
    check("row0_timeout", 32'(n_oeb >= 1), 32'(1));
    check("row0_cclk_edges", 32'(ccnt[0]), 32'(16));
    check("row0_word", 32'(words[0]), 32'(16'h0008));
    check("row0_rsdi", 32'(rsdis[0]), 32'(1));
    check("row0_le_cycles", 32'(n_le_tot), 32'(1));
    check("row0_oeb_low", 32'(oeb_runs[0]), 32'(2 ** TW));
    check("row0_frame_start", 32'(n_fs), 32'(1));

    // Randomized full frame plus wrap into the next frame.
    reset_n = 1'b0;
    enable  = 1'b0;
    tick();
    clear_monitor();
    fb_fill(1'b1);
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 1600 && n_rclk < 17; i++) tick();
    check("frame_timeout", 32'(n_rclk >= 17), 32'(1));
    check("frame_fs_count", 32'(n_fs), 32'(2));
    check("frame_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'(16 * ROW_PERIOD));
    check("row_period", 32'(rclk_cyc[1] - rclk_cyc[0]), 32'(ROW_PERIOD));
    for (int r = 0; r < 16; r++) begin
      check($sformatf("frame_word_r%0d", r), 32'(words[r]), 32'(ref_word(r)));
      check($sformatf("frame_rsdi_r%0d", r), 32'(rsdis[r]), 32'(r == 0));
      check($sformatf("frame_row_r%0d", r), 32'(rows_at[r]), 32'(r));
    end
    check("frame_row_wrap", 32'(rows_at[16]), 32'(0));
    check("frame_oeb_low", 32'(oeb_runs[5]), 32'(2 ** TW));
    check("frame_le_twice", 32'(le_viol), 32'(0));
    check("frame_blank_invariant", 32'(inv_viol), 32'(0));

    // Drop enable while row 5 is displayed.
    for (int i = 0; i < 700 && !(row == 4'd5 && !mx.OEB); i++) tick();
    check("row5_reached", 32'(row == 4'd5 && !mx.OEB), 32'(1));
    enable = 1'b0;
    noeb   = n_oeb;
    for (int i = 0; i < 40 && n_oeb <= noeb; i++) tick();
    check("row5_display_done", 32'(n_oeb > noeb), 32'(1));
    check("row5_oeb_low", 32'(oeb_runs[noeb[5:0]]), 32'(2 ** TW));
    ctot = n_cclk_tot;
    repeat (20) tick();
    check("idle_oeb", 32'(mx.OEB), 32'(1));
    check("idle_row", 32'(row), 32'(6));
    check("idle_no_shift", 32'(n_cclk_tot), 32'(ctot));

    // Re-enable resumes at row 6.
    clear_monitor();
    enable = 1'b1;
    tick();
    check("resume_addr", 32'({mx.pix_y, mx.pix_x}), 32'({4'd6, 4'd15}));
    for (int i = 0; i < 100 && n_rclk < 1; i++) tick();
    check("resume_timeout", 32'(n_rclk >= 1), 32'(1));
    check("resume_row", 32'(rows_at[0]), 32'(6));
    check("resume_word", 32'(words[0]), 32'(ref_word(6)));

    // Asynchronous reset in the middle of column 7 of the next row.
    for (int i = 0; i < 200 && n_cclk_row < 8; i++) tick();
    check("col7_reached", 32'(mx.CCLK), 32'(1));
    reset_n = 1'b0;
    #1;
    check("midreset_pins", 32'({mx.CSDI, mx.CCLK, mx.RSDI, mx.RCLK, mx.LE, mx.OEB, frame_start}),
          32'(7'b0000010));
    check("midreset_row", 32'(row), 32'(0));
    clear_monitor();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10 && n_fs < 1; i++) tick();
    check("restart_frame_start", 32'(n_fs), 32'(1));
    for (int i = 0; i < 100 && n_rclk < 1; i++) tick();
    check("restart_row", 32'(rows_at[0]), 32'(0));
    check("restart_word", 32'(words[0]), 32'(ref_word(0)));
    check("restart_rsdi", 32'(rsdis[0]), 32'(1));

    // Two-cycle pixel latency: the lit pixel arrives after CSDI has sampled.
    reset_n = 1'b0;
    enable  = 1'b0;
    lat2    = 1'b1;
    fb_fill(1'b0);
    fb[0][3] = 1'b1;
    tick();
    clear_monitor();
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 100 && n_rclk < 1; i++) tick();
    check("stale_timeout", 32'(n_rclk >= 1), 32'(1));
    check("stale_cclk_edges", 32'(ccnt[0]), 32'(16));
    check("stale_word", 32'(words[0]), 32'(16'h0000));
    repeat (30) tick();
    check("final_le_twice", 32'(le_viol), 32'(0));
    check("final_blank_invariant", 32'(inv_viol), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan controller for the 16x16 LED matrix display.
- Each cycle of scanning reads one row of the game framebuffer through a pixel read port, then shifts the 16 column bits out on CSDI/CCLK.
- It then advances the row one-hot shift register on RSDI/RCLK, latches the data with LE, and lights the row by holding OEB low for 2^SCREENTIMERWIDTH cycles.
- It sits between the pong game state (pixel source) and the matrix pins, and replaces ad-hoc row timing inside the game core.

Parameters:
- SCREENTIMERWIDTH, 10, width of the row display timer; each row is lit for 2^SCREENTIMERWIDTH clocks. Overridden to small values in tests.
- COLS, 16, columns per row; fixed, with a 5-bit column counter.
- ROWS, 16, rows per frame; fixed, with a 4-bit row counter.

Ports:
- clk32mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; sampled at row boundaries.
- pix_x  out  4  framebuffer column address.
- pix_y  out  4  framebuffer row address (equals the current row).
- pix_in  in  1  pixel value; valid 1 cycle after pix_x/pix_y.
- CSDI  out  1  column shift-register serial data.
- CCLK  out  1  column shift clock.
- RSDI  out  1  row shift-register serial data.
- RCLK  out  1  row shift clock.
- LE  out  1  column latch enable.
- OEB  out  1  output enable, active low.
- frame_start  out  1  1-cycle pulse when row 0 shifting begins.
- row  out  4  current row, for debug.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE; row=0, col=0.
  - CSDI=0, CCLK=0, RSDI=0, RCLK=0, LE=0, OEB=1, frame_start=0, pix_x=0, pix_y=0. Timer=0.
- State machine: IDLE, COL_ADDR, COL_DATA, COL_HI, COL_LO, ROW_SETUP, ROW_HI, ROW_LO, LATCH, DISPLAY.
- IDLE:
  - OEB=1. If enable=1, go to COL_ADDR with col=0 and row unchanged.
  - frame_start pulses on this exit if row==0.
- Column shifting, bits sent column 15 first down to column 0, 4 cycles per bit:
  - COL_ADDR: drive pix_x=15-col, pix_y=row.
  - COL_DATA: CSDI<=pix_in.
  - COL_HI: CCLK=1.
  - COL_LO: CCLK=0, col++. If col was 15, go to ROW_SETUP; otherwise go to COL_ADDR.
  - CSDI is held stable through COL_HI and COL_LO.
- Row shifting:
  - ROW_SETUP: RSDI<=(row==0).
  - ROW_HI: RCLK=1.
  - ROW_LO: RCLK=0.
  - This produces exactly one RCLK pulse per row, so the one-hot bit walks the row register. The injected 1 at row 0 restarts it each frame.
- LATCH: LE=1 for exactly 1 cycle; OEB remains 1.
- DISPLAY:
  - OEB=0; timer counts 0..2^SCREENTIMERWIDTH-1.
  - At terminal count: OEB<=1 and row<=row+1 (15 wraps to 0).
  - Then go to COL_ADDR if enable=1, else IDLE.
  - frame_start pulses when re-entering COL_ADDR with the new row==0.
- Timing:
  - OEB is 1 in every state except DISPLAY (blanking during shift); never low while CCLK, RCLK or LE toggle.
  - Row period is 64+3+1+2^SCREENTIMERWIDTH = 68+2^SCREENTIMERWIDTH cycles. Frame period is 16 times the row period.
- enable:
  - Deassertion mid-row does not abort; the row completes its DISPLAY and the block then parks in IDLE with OEB=1.
  - Reassertion resumes at the stored row.
- Reset mid-operation: all outputs return immediately to their reset values, including OEB=1 (display blanked).
- The timer is SCREENTIMERWIDTH bits wide and wraps naturally; no extra compare width.

Decomposition:
- Shared package pong_pkg holds:
  - the state enum scan_state_t,
  - MATRIX_COLS=16, MATRIX_ROWS=16,
  - COL_BIT_CYCLES=4, ROW_OVERHEAD=4.
- The shift-out sequencer for one serial bit (addr/data/hi/lo) is natural as a sub-module, serial_bit_shifter. It is reused for the row strobe with a fixed data input.

Test Plan (SCREENTIMERWIDTH=4):
- Reset, then enable=1 with a framebuffer holding only pixel (x=3, y=0):
  - Expect 16 CCLK rising edges.
  - CSDI is 1 only on the 13th edge (column 3, sent in 15..0 order).
  - Then one RCLK pulse with RSDI=1, LE high 1 cycle, OEB low exactly 16 cycles.
- Full frame, all pixels 1:
  - Row period is 84 cycles; frame_start pulses are 1344 cycles apart.
  - RSDI=1 on only 1 of 16 RCLK pulses per frame.
  - row sequence is 0..15,0.
- Drop enable during DISPLAY of row 5:
  - OEB still completes its 16 low cycles.
  - Then IDLE with OEB=1 and row=6.
  - Reassert enable: next shifting reads pix_y=6.
- Invariant check throughout: OEB=1 whenever CCLK, RCLK or LE is 1; LE never asserted twice per row.
- Assert reset_n=0 mid column shift (col 7):
  - Outputs go to reset values the same cycle (OEB=1, CCLK=0).
  - After release with enable=1, scanning restarts at row 0 with a frame_start pulse.
- Pixel latency check: pix_in changes 2 cycles after the address instead of 1. Expect CSDI to capture the stale value, documenting the 1-cycle read requirement.
